// File: rtl/ad79x8_scan_sequencer.sv
// Sequencer for the AD79X8 SPI core: power-up dummy transfers, then channel scans
// that program the next enabled channel on every transfer and decode the returned word.
module ad79x8_scan_sequencer #(
  parameter int PACE_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic [7:0]  channel_mask,
  input  logic        range_sel,
  input  logic        coding_sel,
  output logic        spi_initiate,
  input  logic        spi_ready,
  output logic [15:0] spi_tx,
  input  logic [15:0] spi_rx,
  output logic        result_valid,
  output logic [2:0]  result_channel,
  output logic [11:0] result_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_CAPTURE   = 3'd5,
    S_PACE      = 3'd6
  } state_e;

  // Next set mask bit strictly after cur, wrapping; returns cur for a single-bit mask.
  function automatic logic [2:0] next_chan(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = cur + 3'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, m[i]};
    end
    return c;
  endfunction

  state_e            state_q, state_d;
  logic              powered_up_q, powered_up_d;
  logic              dummy_cnt_q, dummy_cnt_d;
  logic              cont_q, cont_d;
  logic [7:0]        mask_q, mask_d;
  logic              range_q, range_d;
  logic              coding_q, coding_d;
  logic [2:0]        addr_q, addr_d;
  logic              prime_q, prime_d;
  logic              stop_pend_q, stop_pend_d;
  logic [3:0]        res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              spi_initiate_q, spi_initiate_d;
  logic [15:0]       spi_tx_q, spi_tx_d;
  logic              result_valid_q, result_valid_d;
  logic [2:0]        result_channel_q, result_channel_d;
  logic [11:0]       result_data_q, result_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              start_ok_s;
  logic              tmo_s;
  logic              pace_done_s;
  logic              last_s;
  logic              end_s;
  logic [15:0]       ctrl_word_s;
  logic              unused_s;

  assign start_ok_s  = start && (channel_mask != 8'd0);
  assign tmo_s       = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign pace_done_s = (cnt_q == CNT_W'(PACE_CYCLES - 1));
  assign last_s      = !prime_q && ((res_cnt_q + 4'd1) == popcount8(mask_q));
  assign end_s       = stop_pend_q || (last_s && !cont_q);
  assign ctrl_word_s = {1'b1, 1'b0, 1'b0, addr_q, 2'b11, 1'b0, 1'b0, range_q, coding_q, 4'b0000};
  // Leading zero bit of the ADC output word carries no information.
  assign unused_s    = spi_rx[15];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:      state_d = spi_ready ? (powered_up_q ? S_IDLE : S_ISSUE) : S_INIT;
      S_IDLE:      state_d = start_ok_s ? S_ISSUE : S_IDLE;
      S_ISSUE:     state_d = spi_ready ? S_WAIT_BUSY : S_ISSUE;
      S_WAIT_BUSY: state_d = !spi_ready ? S_WAIT_DONE : (tmo_s ? S_INIT : S_WAIT_BUSY);
      S_WAIT_DONE: state_d = spi_ready ? S_CAPTURE : (tmo_s ? S_INIT : S_WAIT_DONE);
      S_CAPTURE: begin
        if (!powered_up_q) begin
          state_d = dummy_cnt_q ? S_IDLE : S_PACE;
        end else begin
          state_d = end_s ? S_IDLE : S_PACE;
        end
      end
      S_PACE:      state_d = pace_done_s ? S_ISSUE : S_PACE;
      default:     state_d = S_INIT;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    powered_up_d     = powered_up_q;
    dummy_cnt_d      = dummy_cnt_q;
    cont_d           = cont_q;
    mask_d           = mask_q;
    range_d          = range_q;
    coding_d         = coding_q;
    addr_d           = addr_q;
    prime_d          = prime_q;
    stop_pend_d      = stop_pend_q;
    res_cnt_d        = res_cnt_q;
    cnt_d            = cnt_q;
    spi_initiate_d   = 1'b0;
    spi_tx_d         = spi_tx_q;
    result_valid_d   = 1'b0;
    result_channel_d = result_channel_q;
    result_data_d    = result_data_q;
    busy_d           = (state_d != S_IDLE);
    done_d           = 1'b0;
    error_d          = error_q;
    case (state_q)
      S_INIT: cnt_d = {CNT_W{1'b0}};
      S_IDLE: begin
        if (start_ok_s) begin
          cont_d      = continuous;
          mask_d      = channel_mask;
          range_d     = range_sel;
          coding_d    = coding_sel;
          error_d     = 1'b0;
          addr_d      = next_chan(channel_mask, 3'd7);
          prime_d     = 1'b1;
          res_cnt_d   = 4'd0;
          stop_pend_d = 1'b0;
        end else if (start) begin
          error_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          error_d = error_q;
        end
      end
      S_ISSUE: begin
        cnt_d = {CNT_W{1'b0}};
        if (spi_ready) begin
          spi_initiate_d = 1'b1;
          spi_tx_d       = powered_up_q ? ctrl_word_s : 16'hFFFF;
          addr_d         = powered_up_q ? next_chan(mask_q, addr_q) : addr_q;
        end else begin
          spi_initiate_d = 1'b0;
        end
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        if ((state_q == S_WAIT_DONE) && spi_ready) begin
          cnt_d = {CNT_W{1'b0}};
        end else if ((state_q == S_WAIT_BUSY) && !spi_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (tmo_s) begin
          // A hung core never reruns the power-up dummies.
          cnt_d        = {CNT_W{1'b0}};
          error_d      = 1'b1;
          done_d       = 1'b1;
          powered_up_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        cnt_d = {CNT_W{1'b0}};
        if (!powered_up_q) begin
          dummy_cnt_d  = 1'b1;
          powered_up_d = dummy_cnt_q;
        end else begin
          if (prime_q) begin
            prime_d = 1'b0;
          end else begin
            result_valid_d   = 1'b1;
            result_channel_d = spi_rx[14:12];
            result_data_d    = spi_rx[11:0];
            res_cnt_d        = res_cnt_q + 4'd1;
          end
          if (end_s) begin
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else if (last_s) begin
            res_cnt_d = 4'd0;
          end else begin
            done_d = 1'b0;
          end
        end
      end
      S_PACE: cnt_d = pace_done_s ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));
      default: cnt_d = {CNT_W{1'b0}};
    endcase
    if (stop && (state_q != S_IDLE)) begin
      stop_pend_d = 1'b1;
    end else begin
      stop_pend_d = stop_pend_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      powered_up_q     <= 1'b0;
      dummy_cnt_q      <= 1'b0;
      cont_q           <= 1'b0;
      mask_q           <= 8'd0;
      range_q          <= 1'b0;
      coding_q         <= 1'b0;
      addr_q           <= 3'd0;
      prime_q          <= 1'b0;
      stop_pend_q      <= 1'b0;
      res_cnt_q        <= 4'd0;
      cnt_q            <= {CNT_W{1'b0}};
      spi_initiate_q   <= 1'b0;
      spi_tx_q         <= 16'hFFFF;
      result_valid_q   <= 1'b0;
      result_channel_q <= 3'd0;
      result_data_q    <= 12'd0;
      busy_q           <= 1'b1;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      powered_up_q     <= powered_up_d;
      dummy_cnt_q      <= dummy_cnt_d;
      cont_q           <= cont_d;
      mask_q           <= mask_d;
      range_q          <= range_d;
      coding_q         <= coding_d;
      addr_q           <= addr_d;
      prime_q          <= prime_d;
      stop_pend_q      <= stop_pend_d;
      res_cnt_q        <= res_cnt_d;
      cnt_q            <= cnt_d;
      spi_initiate_q   <= spi_initiate_d;
      spi_tx_q         <= spi_tx_d;
      result_valid_q   <= result_valid_d;
      result_channel_q <= result_channel_d;
      result_data_q    <= result_data_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      error_q          <= error_d;
    end
  end

  assign spi_initiate   = spi_initiate_q;
  assign spi_tx         = spi_tx_q;
  assign result_valid   = result_valid_q;
  assign result_channel = result_channel_q;
  assign result_data    = result_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_ad79x8_scan_sequencer.sv
// Bench for ad79x8_scan_sequencer: SPI core model answering with the previously
// programmed channel, and a result scoreboard filled when each scan is started.
module tb_ad79x8_scan_sequencer;

  localparam int XFER = 20;
  localparam int PACE = 16;
  localparam int TMO  = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [7:0]  channel_mask = 8'd0;
  logic        range_sel = 1'b0;
  logic        coding_sel = 1'b0;
  logic        spi_initiate;
  logic        spi_ready = 1'b1;
  logic [15:0] spi_tx;
  logic [15:0] spi_rx = 16'h0000;
  logic        result_valid;
  logic [2:0]  result_channel;
  logic [11:0] result_data;
  logic        busy;
  logic        done;
  logic        error;

  ad79x8_scan_sequencer #(.PACE_CYCLES(PACE), .TIMEOUT_CYCLES(TMO), .CNT_W(11)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .channel_mask(channel_mask), .range_sel(range_sel), .coding_sel(coding_sel),
    .spi_initiate(spi_initiate), .spi_ready(spi_ready), .spi_tx(spi_tx), .spi_rx(spi_rx),
    .result_valid(result_valid), .result_channel(result_channel), .result_data(result_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rx_data(input logic [2:0] a);
    return {~a, a, 6'h2D};
  endfunction

  function automatic logic [15:0] ctrl_word(input logic [2:0] a, input logic r, input logic c);
    return {1'b1, 1'b0, 1'b0, a, 2'b11, 1'b0, 1'b0, r, c, 4'b0000};
  endfunction

  // SPI core model: ready low for XFER cycles per transfer (frozen while hang is set).
  int          busy_cnt = 0;
  logic [15:0] cur_tx = 16'hFFFF;
  logic [2:0]  prev_addr = 3'd7;
  logic        hang = 1'b0;
  always @(posedge clk) begin
    if (spi_initiate) begin
      cur_tx    <= spi_tx;
      busy_cnt  <= XFER;
      spi_ready <= 1'b0;
    end else if (busy_cnt > 0 && !hang) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        spi_ready <= 1'b1;
        spi_rx    <= {1'b0, prev_addr, rx_data(prev_addr)};
        prev_addr <= cur_tx[12:10];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_init, n_done, n_valid, init_busy, last_init_cyc, min_gap;
  bit          have_last;
  logic [15:0] tx_log[$];
  logic [14:0] got_q[$];
  logic [14:0] exp_q[$];
  int          checks = 0;
  int          fails = 0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (spi_initiate === 1'b1) begin
      n_init++;
      tx_log.push_back(spi_tx);
      if (spi_ready !== 1'b1) init_busy++;
      if (have_last && (cyc - last_init_cyc) < min_gap) min_gap = cyc - last_init_cyc;
      last_init_cyc = cyc;
      have_last = 1'b1;
    end
    if (result_valid === 1'b1) begin
      n_valid++;
      got_q.push_back({result_channel, result_data});
    end
    if (done === 1'b1) n_done++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_mon();
    n_init = 0; n_done = 0; n_valid = 0; have_last = 1'b0; min_gap = 1000000;
    tx_log.delete(); got_q.delete(); exp_q.delete();
  endtask

  task automatic pulse_start(input logic [7:0] m, input logic c, input logic r, input logic cd, input logic with_stop);
    @(posedge clk); #1;
    channel_mask = m; continuous = c; range_sel = r; coding_sel = cd;
    start = 1'b1; stop = with_stop;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (n_done > 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    clear_mon();
    tick(3);
    @(negedge clk);
    checks++;
    if ({spi_initiate, spi_tx, result_valid} !== {1'b0, 16'hFFFF, 1'b0}) begin
      fails++; $display("FAIL reset_spi: got init=%b tx=%h rv=%b required 0 ffff 0", spi_initiate, spi_tx, result_valid);
    end
    checks++;
    if ({result_channel, result_data} !== 15'd0) begin
      fails++; $display("FAIL reset_result: got ch=%0d data=%h required 0 000", result_channel, result_data);
    end
    checks++;
    if ({busy, done, error} !== 3'b100) begin
      fails++; $display("FAIL reset_flags: got busy/done/error=%b required 100", {busy, done, error});
    end
    @(posedge clk); #1 reset = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL powerup_idle: busy never fell within 400 cycles"); end
    checks++;
    if (n_init != 2) begin fails++; $display("FAIL powerup_count: got %0d transfers required 2", n_init); end
    for (int i = 0; i < tx_log.size(); i++) begin
      checks++;
      if (tx_log[i] !== 16'hFFFF) begin fails++; $display("FAIL powerup_tx%0d: got %h required ffff", i, tx_log[i]); end
    end
    checks++;
    if (n_valid != 0 || n_done != 0) begin
      fails++; $display("FAIL powerup_quiet: got valid=%0d done=%0d required 0 0", n_valid, n_done);
    end
  endtask

  task automatic test_single_pass();
    bit ok;
    logic [2:0]  ea[4] = '{3'd0, 3'd2, 3'd7, 3'd0};
    logic [14:0] e, g;
    clear_mon();
    exp_q.push_back({3'd0, rx_data(3'd0)});
    exp_q.push_back({3'd2, rx_data(3'd2)});
    exp_q.push_back({3'd7, rx_data(3'd7)});
    pulse_start(8'b1000_0101, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(1000, ok);
    tick(80);
    checks++;
    if (!ok) begin fails++; $display("FAIL single_done: no done within 1000 cycles"); end
    checks++;
    if (n_init != 4) begin fails++; $display("FAIL single_count: got %0d transfers required 4", n_init); end
    for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
      checks++;
      if (tx_log[i] !== ctrl_word(ea[i], 1'b0, 1'b0)) begin
        fails++; $display("FAIL single_tx%0d: got %h required %h", i, tx_log[i], ctrl_word(ea[i], 1'b0, 1'b0));
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL single_nres: got %0d results required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL single_result: got ch=%0d data=%h required ch=%0d data=%h", g[14:12], g[11:0], e[14:12], e[11:0]); end
    end
    checks++;
    if (n_done != 1 || busy !== 1'b0 || error !== 1'b0) begin
      fails++; $display("FAIL single_end: got done=%0d busy=%b error=%b required 1 0 0", n_done, busy, error);
    end
  endtask

  task automatic test_range_coding();
    bit ok;
    logic [14:0] e, g;
    clear_mon();
    exp_q.push_back({3'd4, rx_data(3'd4)});
    // stop together with start in IDLE: start must win and the pass run to completion
    pulse_start(8'h10, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done(1000, ok);
    tick(80);
    checks++;
    if (!ok || n_init != 2) begin fails++; $display("FAIL rc_count: got done=%b transfers=%0d required 1 2", ok, n_init); end
    foreach (tx_log[i]) begin
      checks++;
      if (tx_log[i] !== 16'h9330) begin fails++; $display("FAIL rc_tx%0d: got %h required 9330", i, tx_log[i]); end
    end
    checks++;
    if (got_q.size() != 1) begin fails++; $display("FAIL rc_nres: got %0d results required 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL rc_result: got %h required %h", g, e); end
    end
  endtask

  task automatic test_continuous_stop();
    bit ok;
    logic [2:0]  ea[4] = '{3'd0, 3'd1, 3'd0, 3'd1};
    logic [14:0] e, g;
    clear_mon();
    exp_q.push_back({3'd0, rx_data(3'd0)});
    exp_q.push_back({3'd1, rx_data(3'd1)});
    exp_q.push_back({3'd0, rx_data(3'd0)});
    pulse_start(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (n_init >= 4) ok = 1'b1;
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL cont_run: only %0d transfers within 1000 cycles", n_init); end
    tick(5);
    pulse_stop();
    wait_done(200, ok);
    tick(120);
    checks++;
    if (!ok) begin fails++; $display("FAIL cont_done: no done within 200 cycles of stop"); end
    checks++;
    if (n_init != 4 || n_done != 1 || busy !== 1'b0) begin
      fails++; $display("FAIL cont_end: got transfers=%0d done=%0d busy=%b required 4 1 0", n_init, n_done, busy);
    end
    for (int i = 0; i < 4 && i < tx_log.size(); i++) begin
      checks++;
      if (tx_log[i] !== ctrl_word(ea[i], 1'b0, 1'b0)) begin fails++; $display("FAIL cont_tx%0d: got %h required %h", i, tx_log[i], ctrl_word(ea[i], 1'b0, 1'b0)); end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL cont_nres: got %0d results required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL cont_result: got %h required %h", g, e); end
    end
  endtask

  task automatic test_mask_zero();
    clear_mon();
    pulse_start(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(40);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || n_done != 1) begin fails++; $display("FAIL zero_err: got error=%b done=%0d required 1 1", error, n_done); end
    checks++;
    if (n_init != 0 || busy !== 1'b0) begin fails++; $display("FAIL zero_idle: got transfers=%0d busy=%b required 0 0", n_init, busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    int t_err, n_before;
    logic [14:0] e, g;
    clear_mon();
    hang = 1'b1;
    pulse_start(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    ok = 1'b0; t_err = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (error === 1'b1) begin ok = 1'b1; t_err = cyc; end
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL tmo_err: error not raised within 2000 cycles"); end
    checks++;
    if (t_err - last_init_cyc < TMO - 1 || t_err - last_init_cyc > TMO + 2) begin
      fails++; $display("FAIL tmo_time: got %0d cycles initiate-to-error required %0d", t_err - last_init_cyc, TMO);
    end
    tick(3);
    @(negedge clk);
    checks++;
    if (n_done != 1 || busy !== 1'b1 || n_valid != 0) begin
      fails++; $display("FAIL tmo_state: got done=%0d busy=%b valid=%0d required 1 1 0", n_done, busy, n_valid);
    end
    n_before = n_init;
    hang = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok || n_init != n_before || error !== 1'b1) begin
      fails++; $display("FAIL tmo_recover: got idle=%b transfers=%0d error=%b required 1 %0d 1", ok, n_init, error, n_before);
    end
    clear_mon();
    exp_q.push_back({3'd0, rx_data(3'd0)});
    pulse_start(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (error !== 1'b0) begin fails++; $display("FAIL tmo_clear: got error=%b required 0 after start", error); end
    wait_done(1000, ok);
    tick(80);
    checks++;
    if (!ok || n_init != 2 || error !== 1'b0) begin
      fails++; $display("FAIL tmo_rescan: got done=%b transfers=%0d error=%b required 1 2 0", ok, n_init, error);
    end
    checks++;
    if (got_q.size() != 1) begin fails++; $display("FAIL tmo_nres: got %0d results required 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL tmo_result: got %h required %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [14:0] e, g;
    clear_mon();
    for (int c = 0; c < 4; c++) exp_q.push_back({3'(c), rx_data(3'(c))});
    pulse_start(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 1500 && !ok; i++) begin
      @(negedge clk);
      if (n_init >= 5) ok = 1'b1;
    end
    tick(5);
    pulse_stop();
    wait_done(200, ok);
    tick(80);
    checks++;
    if (!ok || n_init != 5) begin fails++; $display("FAIL b2b_count: got done=%b transfers=%0d required 1 5", ok, n_init); end
    checks++;
    if (min_gap < XFER + PACE) begin fails++; $display("FAIL b2b_pace: got min gap %0d cycles required >= %0d", min_gap, XFER + PACE); end
    checks++;
    if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_nres: got %0d results required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin fails++; $display("FAIL b2b_result: got %h required %h", g, e); end
    end
    checks++;
    if (init_busy != 0) begin fails++; $display("FAIL init_while_busy: got %0d initiates with ready low required 0", init_busy); end
  endtask

  initial begin
    init_busy = 0;
    test_reset();
    test_single_pass();
    test_range_coding();
    test_continuous_stop();
    test_mask_zero();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ad79x8_scan_sequencer.md
Name: ad79x8_scan_sequencer

Overview:
- Sequences the AD79X8 SPI interface core, the SPI front end for the AD7908/AD7918/AD7928.
- Performs the power-up dummy conversions, then writes a control word on every transfer to select the next enabled channel.
- Decodes each returned word into a channel/data result stream.
- Supports single-pass or continuous scanning, with conversion-rate pacing and a transfer watchdog.

Parameters:
- PACE_CYCLES, 16: minimum clk cycles from one transfer completing to the next spi_initiate; must be ≥1.
- TIMEOUT_CYCLES, 1024: maximum clk cycles spi_ready may stay low before an error is raised.
- CNT_W, 11: width of the pace/timeout counter; must hold max(PACE_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock; same clock as the SPI core.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a scan. Ignored unless the block is idle.
- stop  in  1  one-cycle pulse; ends a continuous scan after the in-flight transfer.
- continuous  in  1  sampled at start: 1 = repeat passes, 0 = single pass.
- channel_mask  in  8  enabled channels, sampled at start.
- range_sel  in  1  RANGE bit of the control word, sampled at start.
- coding_sel  in  1  CODING bit of the control word, sampled at start.
- spi_initiate  out  1  transfer request to the SPI core.
- spi_ready  in  1  SPI core idle flag; low while a transfer is in progress.
- spi_tx  out  16  word driven onto the SPI core bus_in.
- spi_rx  in  16  word from the SPI core bus_out.
- result_valid  out  1  one-cycle strobe.
- result_channel  out  3  channel ID, taken from spi_rx[14:12].
- result_data  out  12  spi_rx[11:0]; for AD7908/7918 the low LSBs are zero.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a pass or stop completes.
- error  out  1  sticky; cleared by reset or a start that is accepted.

Behaviour:
- Reset values: spi_initiate=0, spi_tx=16'hFFFF, result_valid=0, result_channel=0, result_data=0, busy=1 (in INIT), done=0, error=0, powered_up=0.
- States: INIT, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE, PACE.
- INIT: wait for spi_ready=1. If powered_up=0, run two dummy transfers with spi_tx=16'hFFFF (DIN high, control register not written), then set powered_up=1 and go to IDLE. Dummy results are never reported.
- IDLE:
  - start with channel_mask≠0: latch the configuration, clear error, point at the lowest set mask bit, set prime=1, go to ISSUE.
  - start with channel_mask=0: error=1, done pulse, stay in IDLE.
- ISSUE: requires spi_ready=1.
  - spi_initiate=1 for exactly one cycle.
  - spi_tx = {1'b1 WRITE, 1'b0 SEQ, 1'b0, addr[2:0], 2'b11 PM normal, 1'b0 SHADOW, 1'b0, range, coding, 4'b0000}, held stable until WAIT_DONE exits.
  - After issuing, advance addr to the next set mask bit above it, wrapping to the lowest set bit.
- WAIT_BUSY: wait for spi_ready=0. WAIT_DONE: wait for spi_ready=1.
  - The timeout counter runs across both states. If it reaches TIMEOUT_CYCLES: error=1, done pulse, go to INIT. The dummy sequence is not rerun.
- CAPTURE: one cycle.
  - If prime=1: clear prime and discard the result; it belongs to the previously programmed address.
  - Otherwise: result_valid=1 with result_channel and result_data from spi_rx, and increment the result count.
- Pass end: the result count equals popcount(mask).
  - Single mode: a pass is N+1 transfers for N enabled channels. At pass end, done pulse, go to IDLE.
  - Continuous mode: reset the count and continue without re-priming.
- Stop: stop during any busy state sets a pending flag. At the next CAPTURE, the in-flight result is still reported, then done pulse and go to IDLE. stop while idle is ignored.
- PACE: count PACE_CYCLES clocks from CAPTURE, then go to ISSUE. The count restarts on every entry.
- Simultaneous start and stop in IDLE: start wins.
- Mask, range or coding changes mid-scan take effect only at the next accepted start.
- Reset mid-transfer: go to INIT and wait for spi_ready=1 before the dummy sequence. spi_initiate is never asserted while spi_ready=0.
- Single-channel mask: addr stays constant and every transfer rewrites the same channel.

Test Plan:
- After reset, model ready low for 20 cycles on each transfer: exactly two transfers with spi_tx=16'hFFFF; busy falls after the 2nd; no result_valid.
- mask=8'b1000_0101, continuous=0, start; model returns channel ID = previous address: transfers addr 0,2,7,0; results ch0, ch2, ch7 in order; one done pulse; 4 transfers total.
- range=1, coding=1, mask=8'h10: spi_tx=16'h9330 on every transfer.
- Continuous scan with mask=8'h03, stop pulse mid-transfer: that transfer's result is delivered, then done, busy=0, and no further spi_initiate.
- Model holds spi_ready low forever: error=1 after TIMEOUT_CYCLES, state INIT; a later start with ready healthy clears error and scans.
- start with mask=0: error=1, done pulse, no spi_initiate. PACE_CYCLES=16: initiate-to-initiate gap ≥ transfer time + 16 clk.
